relu_grad_mask: RTL and testbench

- Backward-direction companion to the activation stage.
- Forward side: captures one mask bit per activation entering the ReLU (pass = sign bit clear) into a mask FIFO.
- Backward side: gates the matching gradient stream, returning the gradient where the forward activation passed and zero where it was clamped.
- Sits between the bound/activation stage (forward tap) and the gradient return path to the preceding layer.

---
 rtl/relu_grad_mask.sv | 106 ++++++++++
 tb/tb_relu_grad_mask.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/relu_grad_mask.sv
// Backward ReLU mask: records a pass/clamp bit per forward activation and gates
// the returning gradient stream with it. Optional zero statistic: RELU_GRAD_MASK_STAT_EN.
module relu_grad_mask #(
    parameter int D_BW  = 8,
    parameter int G_BW  = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_clear,
    input  logic            i_fwd_valid,
    output logic            o_fwd_ready,
    input  logic [D_BW-1:0] i_fwd_data,
    input  logic            i_bwd_valid,
    output logic            o_bwd_ready,
    input  logic [G_BW-1:0] i_bwd_grad,
    output logic            o_grad_valid,
    input  logic            i_grad_ready,
    output logic [G_BW-1:0] o_grad_data,
    output logic [AW:0]     o_mask_count,
    output logic [15:0]     o_zero_cnt
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic            mask_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push;
    logic            pop;
    logic            fwd_mask;
    logic            rd_mask;
    logic            unused_fwd_bits;

    // Only the sign bit of the activation matters; zero counts as a pass.
    assign fwd_mask        = ~i_fwd_data[D_BW-1];
    assign unused_fwd_bits = ^i_fwd_data[D_BW-2:0];
    assign rd_mask         = mask_mem[rd_ptr];

    assign o_fwd_ready  = (count != FULL_CNT);
    assign o_bwd_ready  = (count != '0) && (!o_grad_valid || i_grad_ready);
    assign push         = i_fwd_valid && o_fwd_ready;
    assign pop          = i_bwd_valid && o_bwd_ready;
    assign o_mask_count = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push && !i_clear) mask_mem[wr_ptr] <= fwd_mask;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_grad_valid <= 1'b0;
            o_grad_data  <= '0;
        end else if (i_clear) begin
            o_grad_valid <= 1'b0;
            o_grad_data  <= '0;
        end else if (pop) begin
            o_grad_valid <= 1'b1;
            o_grad_data  <= rd_mask ? i_bwd_grad : '0;
        end else if (i_grad_ready) begin
            o_grad_valid <= 1'b0;
        end
    end

`ifdef RELU_GRAD_MASK_STAT_EN
    logic [15:0] zero_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero_cnt <= '0;
        end else if (i_clear) begin
            zero_cnt <= '0;
        end else if (pop && !rd_mask && (zero_cnt != 16'hFFFF)) begin
            zero_cnt <= zero_cnt + 16'd1;
        end
    end

    assign o_zero_cnt = zero_cnt;
`else
    assign o_zero_cnt = '0;
`endif

endmodule

// File: tb/tb_relu_grad_mask.sv
// Scoreboard bench for relu_grad_mask: queue-based mask model, decoupled output monitor.
module tb_relu_grad_mask;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_fwd_valid = 1'b0;
    logic       o_fwd_ready;
    logic [7:0] i_fwd_data = '0;
    logic       i_bwd_valid = 1'b0;
    logic       o_bwd_ready;
    logic [7:0] i_bwd_grad = '0;
    logic       o_grad_valid;
    logic       i_grad_ready = 1'b0;
    logic [7:0] o_grad_data;
    logic [4:0] o_mask_count;
    logic [15:0] o_zero_cnt;

    relu_grad_mask #(.D_BW(8), .G_BW(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .i_clear(i_clear),
        .i_fwd_valid(i_fwd_valid), .o_fwd_ready(o_fwd_ready), .i_fwd_data(i_fwd_data),
        .i_bwd_valid(i_bwd_valid), .o_bwd_ready(o_bwd_ready), .i_bwd_grad(i_bwd_grad),
        .o_grad_valid(o_grad_valid), .i_grad_ready(i_grad_ready), .o_grad_data(o_grad_data),
        .o_mask_count(o_mask_count), .o_zero_cnt(o_zero_cnt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    bit         mq[$];          // pending mask bits, oldest first
    logic [7:0] exp_q[$];       // expected masked gradients, in output order
    bit         mvalid = 1'b0;  // model of the output register's valid
    int         zcnt = 0;

    function automatic int exp_zero();
`ifdef RELU_GRAD_MASK_STAT_EN
        return zcnt;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic flush_model();
        mq.delete();
        exp_q.delete();
        mvalid = 1'b0;
        zcnt = 0;
    endtask

    // One clock of stimulus; called just after a rising edge, returns just after the next.
    task automatic cycle(input bit fv, input logic [7:0] fd, input bit bv,
                         input logic [7:0] bg, input bit gr, input bit clr);
        bit exp_bwd, push, pop, m;
        i_fwd_valid = fv; i_fwd_data = fd; i_bwd_valid = bv;
        i_bwd_grad = bg; i_grad_ready = gr; i_clear = clr;
        @(negedge clk);
        exp_bwd = (mq.size() != 0) && (!mvalid || gr);
        chk("fwd_ready", o_fwd_ready, mq.size() != DEPTH);
        chk("bwd_ready", o_bwd_ready, exp_bwd);
        chk("mask_count", o_mask_count, mq.size());
        chk("grad_valid", o_grad_valid, mvalid);
        chk("zero_cnt", o_zero_cnt, exp_zero());
        if (clr) begin
            flush_model();
        end else begin
            push = fv && (mq.size() != DEPTH);
            pop  = bv && exp_bwd;
            if (pop) begin
                m = mq.pop_front();
                exp_q.push_back(m ? bg : 8'h00);
                if (!m && zcnt != 16'hFFFF) zcnt++;
                mvalid = 1'b1;
            end else if (gr) begin
                mvalid = 1'b0;
            end
            if (push) mq.push_back(~fd[7]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 8'h00, 0, 8'h00, 1, 0);
    endtask

    // Monitor: every output handshake consumes one scoreboard entry.
    always @(negedge clk) begin
        logic [7:0] e;
        if (reset_n && !i_clear && o_grad_valid && i_grad_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected actual=%0h required=none t=%0t", o_grad_data, $time);
            end else begin
                e = exp_q.pop_front();
                if (o_grad_data !== e) begin
                    failures++;
                    $display("FAIL out_data actual=%0h required=%0h t=%0t", o_grad_data, e, $time);
                end
            end
        end
    end

    initial begin
        logic [7:0] held;
        logic [7:0] acts [4];
        logic [7:0] grads [4];
        acts  = '{8'h05, 8'h80, 8'h00, 8'hFF};
        grads = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset with valids high
        i_fwd_valid = 1; i_bwd_valid = 1; i_grad_ready = 1; i_fwd_data = 8'h01; i_bwd_grad = 8'hAA;
        repeat (3) @(negedge clk);
        chk("rst_fwd_ready", o_fwd_ready, 1);
        chk("rst_bwd_ready", o_bwd_ready, 0);
        chk("rst_grad_valid", o_grad_valid, 0);
        chk("rst_mask_count", o_mask_count, 0);
        chk("rst_zero_cnt", o_zero_cnt, 0);
        chk("rst_grad_data", o_grad_data, 0);
        i_fwd_valid = 0; i_bwd_valid = 0;
        reset_n = 1;
        @(posedge clk); #1;

        // Basic mask
        for (int k = 0; k < 4; k++) cycle(1, acts[k], 0, 8'h00, 1, 0);
        for (int k = 0; k < 4; k++) cycle(0, 8'h00, 1, grads[k], 1, 0);
        idle(2);
        chk("basic_zero_cnt", o_zero_cnt, exp_zero());
        chk("basic_drained", exp_q.size(), 0);

        // Full and wrap
        for (int k = 0; k < DEPTH + 1; k++) cycle(1, 8'($urandom_range(0, 127)), 0, 8'h00, 1, 0);
        chk("full_count", o_mask_count, DEPTH);
        chk("full_fwd_ready", o_fwd_ready, 0);
        for (int k = 0; k < 40; k++)
            cycle(1, 8'($urandom), 1, 8'($urandom), 1, 0);
        chk("wrap_count", o_mask_count, mq.size());

        // Backpressure
        cycle(0, 8'h00, 1, 8'h3C, 0, 0);
        held = o_grad_data;
        for (int k = 0; k < 3; k++) begin
            cycle(0, 8'h00, 1, 8'($urandom), 0, 0);
            chk("hold_data", o_grad_data, held);
            chk("hold_valid", o_grad_valid, 1);
        end
        for (int k = 0; k < 6; k++) cycle(0, 8'h00, 1, 8'($urandom), 1, 0);
        while (mq.size() != 0) cycle(0, 8'h00, 1, 8'($urandom), 1, 0);
        idle(2);

        // Empty race
        chk("race_empty", o_mask_count, 0);
        cycle(1, 8'h7F, 1, 8'h5A, 1, 0);
        chk("race_push_only", o_grad_valid, 0);
        cycle(0, 8'h00, 1, 8'h5A, 1, 0);
        chk("race_out_valid", o_grad_valid, 1);
        chk("race_out_data", o_grad_data, 8'h5A);
        idle(1);

        // Synchronous clear mid-stream
        for (int k = 0; k < 6; k++) cycle(1, 8'($urandom), 0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 8'h77, 0, 0);
        chk("clr_pre_valid", o_grad_valid, 1);
        chk("clr_pre_count", o_mask_count, 5);
        cycle(1, 8'h01, 1, 8'h66, 1, 1);
        chk("clr_count", o_mask_count, 0);
        chk("clr_valid", o_grad_valid, 0);
        chk("clr_data", o_grad_data, 0);
        chk("clr_zero", o_zero_cnt, 0);
        idle(1);

        // Asynchronous reset mid-stream
        for (int k = 0; k < 6; k++) cycle(1, 8'($urandom), 0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 8'h99, 0, 0);
        i_bwd_valid = 0; i_grad_ready = 1;
        #2 reset_n = 0;
        #1;
        chk("arst_count", o_mask_count, 0);
        chk("arst_valid", o_grad_valid, 0);
        chk("arst_data", o_grad_data, 0);
        chk("arst_fwd_ready", o_fwd_ready, 1);
        chk("arst_bwd_ready", o_bwd_ready, 0);
        chk("arst_zero", o_zero_cnt, 0);
        flush_model();
        #3 reset_n = 1;
        @(posedge clk); #1;

        // Random traffic
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
                  8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
        while (mq.size() != 0) cycle(0, 8'h00, 1, 8'($urandom), 1, 0);
        idle(2);
        chk("final_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
